// File: rtl/lcd_wr_arbiter.sv
// Sequences init -> picture/char draws onto the single LCD write engine, with a per-word watchdog.
// Mux/done routing is combinational; draws start two cycles after a request edge, and wr_done is the only backpressure.
module lcd_wr_arbiter #(
  parameter bit          AUTO_PIC       = 1'b1,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [8:0] init_data,
  input  logic       init_en,
  input  logic       init_done,
  input  logic [8:0] pic_data,
  input  logic       pic_en,
  input  logic       pic_done,
  input  logic [8:0] char_data,
  input  logic       char_en,
  input  logic       char_done,
  input  logic       pic_req,
  input  logic       char_req,
  input  logic       wr_done,
  output logic [8:0] lcd_wr_data,
  output logic       lcd_wr_en,
  output logic       init_wr_done,
  output logic       pic_wr_done,
  output logic       char_wr_done,
  output logic       show_pic_flag,
  output logic       show_char_flag,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_PIC_START,
    S_PIC,
    S_CHAR_START,
    S_CHAR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        pic_req_q;
  logic        char_req_q;
  logic        pend_pic;
  logic        pend_char;
  logic [23:0] wd_cnt;
  logic        in_draw;
  logic        wd_expire;
  logic        set_timeout;
  logic        set_auto_pic;
  logic        clr_pic;
  logic        clr_char;

  assign in_draw   = (state == S_PIC) || (state == S_CHAR);
  assign wd_expire = in_draw && !wr_done && (wd_cnt == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    state_nxt    = state;
    set_timeout  = 1'b0;
    set_auto_pic = 1'b0;
    clr_pic      = 1'b0;
    clr_char     = 1'b0;
    case (state)
      S_INIT: begin
        if (init_done) begin
          state_nxt    = S_IDLE;
          set_auto_pic = AUTO_PIC;
        end
      end
      S_IDLE: begin
        if (pend_pic) begin
          state_nxt = S_PIC_START;
        end else if (pend_char) begin
          state_nxt = S_CHAR_START;
        end
      end
      S_PIC_START: begin
        clr_pic   = 1'b1;
        state_nxt = S_PIC;
      end
      S_PIC: begin
        // A done arriving on the expiry cycle still counts as a clean finish.
        if (pic_done) begin
          state_nxt = S_IDLE;
        end else if (wd_expire) begin
          state_nxt   = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      S_CHAR_START: begin
        clr_char  = 1'b1;
        state_nxt = S_CHAR;
      end
      S_CHAR: begin
        if (char_done) begin
          state_nxt = S_IDLE;
        end else if (wd_expire) begin
          state_nxt   = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= S_INIT;
      pic_req_q   <= 1'b0;
      char_req_q  <= 1'b0;
      pend_pic    <= 1'b0;
      pend_char   <= 1'b0;
      wd_cnt      <= 24'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pic_req_q   <= pic_req;
      char_req_q  <= char_req;
      // New request edges override the clear issued by the start state.
      pend_pic    <= (pend_pic & ~clr_pic) | (pic_req & ~pic_req_q) | set_auto_pic;
      pend_char   <= (pend_char & ~clr_char) | (char_req & ~char_req_q);
      wd_cnt      <= (in_draw && !wr_done) ? wd_cnt + 24'd1 : 24'd0;
      timeout_err <= timeout_err | set_timeout;
    end
  end

  always_comb begin
    case (state)
      S_INIT:                grant = 2'd0;
      S_PIC_START, S_PIC:    grant = 2'd1;
      S_CHAR_START, S_CHAR:  grant = 2'd2;
      default:               grant = 2'd3;
    endcase
  end

  always_comb begin
    lcd_wr_data = 9'h000;
    lcd_wr_en   = 1'b0;
    case (grant)
      2'd0: begin
        lcd_wr_data = init_data;
        lcd_wr_en   = init_en;
      end
      2'd1: begin
        lcd_wr_data = pic_data;
        lcd_wr_en   = pic_en;
      end
      2'd2: begin
        lcd_wr_data = char_data;
        lcd_wr_en   = char_en;
      end
      default: begin
        lcd_wr_data = 9'h000;
        lcd_wr_en   = 1'b0;
      end
    endcase
  end

  assign init_wr_done   = wr_done && (grant == 2'd0);
  assign pic_wr_done    = wr_done && (grant == 2'd1);
  assign char_wr_done   = wr_done && (grant == 2'd2);
  assign show_pic_flag  = (state == S_PIC_START);
  assign show_char_flag = (state == S_CHAR_START);
  assign busy           = (state != S_IDLE);

endmodule
